// File: rtl/minas_pkg.sv
// Shared definitions for the minesweeper board placement slice:
// board geometry, cell codes, index types and the controller states.
package minas_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CELLS = ROWS * COLS;
  localparam logic [3:0] MINE_CODE = 4'd9;

  typedef logic [5:0] cell_idx_t;
  typedef logic [2:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RND,
    SCAN,
    DONE
  } ctrl_state_e;

  // Row-major cell index; with 8 columns this is just {row, col}.
  function automatic cell_idx_t cell_index(input coord_t row, input coord_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/mine_neighbor_count.sv
// Counts the mines surrounding one cell of the board. Neighbours that fall
// off the edge of the board contribute nothing; there is no wrap-around.
module mine_neighbor_count
  import minas_pkg::*;
(
  input  logic [63:0] mine_map,
  input  cell_idx_t   idx,
  output logic [3:0]  count
);

  // Walk the 3x3 window around idx, skipping the centre and off-board cells.
  always_comb begin
    int        r;
    int        c;
    cell_idx_t nIdx;
    count = '0;
    r     = 0;
    c     = 0;
    nIdx  = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(idx[5:3]) + dr;
        c = int'(idx[2:0]) + dc;
        if ((dr != 0 || dc != 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
          nIdx  = cell_idx_t'(r * COLS + c);
          count = count + 4'(mine_map[nIdx]);
        end
      end
    end
  end

endmodule

// File: rtl/mine_placement_ctrl.sv
// Board setup sequencer: pulls random coordinates until the requested number
// of distinct mines is placed, then streams one code per cell (mine marker or
// neighbour count) into the board cell memory, one cell per cycle.
module mine_placement_ctrl
  import minas_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  total_mines,
  output logic        rnd_req,
  input  logic        rnd_valid,
  input  logic [2:0]  rnd_row,
  input  logic [2:0]  rnd_col,
  output logic [63:0] mine_map,
  output logic [3:0]  placed_count,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [3:0]  wr_data,
  output logic        busy,
  output logic        done
);

  ctrl_state_e state_q, state_d;
  logic [63:0] mineMap_q, mineMap_d;
  logic [3:0]  placedCount_q, placedCount_d;
  logic [3:0]  totalMines_q, totalMines_d;
  cell_idx_t   scanIdx_q, scanIdx_d;
  logic        rndReq_q, rndReq_d;
  logic        wrEn_q, wrEn_d;
  logic [3:0]  wrData_q, wrData_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  nbrCount;
  cell_idx_t   coordIdx;

  // The code for the cell about to be written is computed from the next-cycle
  // map, so a mine placed on the edge that enters SCAN is already visible.
  mine_neighbor_count u_nbr (
    .mine_map (mineMap_d),
    .idx      (scanIdx_d),
    .count    (nbrCount)
  );

  assign coordIdx = cell_index(rnd_row, rnd_col);

  // State and datapath registers; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mineMap_q     <= '0;
      placedCount_q <= '0;
      totalMines_q  <= '0;
      scanIdx_q     <= '0;
      rndReq_q      <= 1'b0;
      wrEn_q        <= 1'b0;
      wrData_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mineMap_q     <= mineMap_d;
      placedCount_q <= placedCount_d;
      totalMines_q  <= totalMines_d;
      scanIdx_q     <= scanIdx_d;
      rndReq_q      <= rndReq_d;
      wrEn_q        <= wrEn_d;
      wrData_q      <= wrData_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state and datapath update: start, placement with duplicate rejection, scan walk.
  always_comb begin
    state_d       = state_q;
    mineMap_d     = mineMap_q;
    placedCount_d = placedCount_q;
    totalMines_d  = totalMines_q;
    scanIdx_d     = scanIdx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mineMap_d     = '0;
          placedCount_d = '0;
          totalMines_d  = total_mines;
          scanIdx_d     = '0;
          state_d       = (total_mines == 4'd0) ? SCAN : REQ;
        end
      end
      REQ: begin
        state_d = WAIT_RND;
      end
      WAIT_RND: begin
        if (rnd_valid) begin
          state_d = REQ;
          if (!mineMap_q[coordIdx]) begin
            mineMap_d[coordIdx] = 1'b1;
            placedCount_d       = placedCount_q + 4'd1;
            if (placedCount_d == totalMines_q) begin
              state_d   = SCAN;
              scanIdx_d = '0;
            end
          end
        end
      end
      SCAN: begin
        if (scanIdx_q == cell_idx_t'(CELLS - 1)) begin
          state_d = DONE;
        end else begin
          scanIdx_d = scanIdx_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are derived from where the controller will be next cycle.
  always_comb begin
    rndReq_d = (state_d == REQ);
    busy_d   = (state_d == REQ) || (state_d == WAIT_RND) || (state_d == SCAN);
    done_d   = (state_d == DONE);
    wrEn_d   = (state_d == SCAN);
    wrData_d = '0;
    if (state_d == SCAN) begin
      wrData_d = mineMap_d[scanIdx_d] ? MINE_CODE : nbrCount;
    end
  end

  assign rnd_req      = rndReq_q;
  assign mine_map     = mineMap_q;
  assign placed_count = placedCount_q;
  assign wr_en        = wrEn_q;
  assign wr_addr      = scanIdx_q;
  assign wr_data      = wrData_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mine_placement_ctrl.sv
// Directed bench for mine_placement_ctrl: plays the random-coordinate source,
// predicts every cell write into a scoreboard queue and compares on output.
module tb_mine_placement_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  total_mines;
  logic        rnd_req;
  logic        rnd_valid;
  logic [2:0]  rnd_row;
  logic [2:0]  rnd_col;
  logic [63:0] mine_map;
  logic [3:0]  placed_count;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        busy;
  logic        done;

  typedef struct {
    logic [5:0] addr;
    logic [3:0] data;
  } wr_t;

  wr_t        expQ[$];
  int         checkCount = 0;
  int         passCount  = 0;
  int         reqCount   = 0;
  int         writeCount = 0;
  logic [3:0] captured[64];

  mine_placement_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .total_mines  (total_mines),
    .rnd_req      (rnd_req),
    .rnd_valid    (rnd_valid),
    .rnd_row      (rnd_row),
    .rnd_col      (rnd_col),
    .mine_map     (mine_map),
    .placed_count (placed_count),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scatter model: every mine bumps the count of each on-board neighbour.
  task automatic pushExpected(input logic [63:0] map);
    int  cnt[64];
    wr_t e;
    for (int i = 0; i < 64; i++) cnt[i] = 0;
    for (int i = 0; i < 64; i++) begin
      if (map[i]) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int r = i / 8 + dr;
            int c = i % 8 + dc;
            if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && c >= 0 && c < 8)
              cnt[r * 8 + c]++;
          end
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      e.addr = 6'(i);
      e.data = map[i] ? 4'd9 : 4'(cnt[i]);
      expQ.push_back(e);
    end
  endtask

  task automatic clearRun();
    reqCount   = 0;
    writeCount = 0;
    for (int i = 0; i < 64; i++) captured[i] = 4'hF;
  endtask

  task automatic applyStimulus(input logic [3:0] n);
    @(negedge clk);
    start       = 1'b1;
    total_mines = n;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic waitReq(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (rnd_req) got = 1'b1;
      else @(negedge clk);
    end
    checkOutput(tag, 64'(got), 64'd1);
  endtask

  task automatic serveRnd(input logic [2:0] r, input logic [2:0] c, input int d);
    waitReq("rnd_req_seen");
    repeat (d) @(negedge clk);
    rnd_row   = r;
    rnd_col   = c;
    rnd_valid = 1'b1;
    @(negedge clk);
    rnd_valid = 1'b0;
  endtask

  task automatic waitDone();
    logic got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    checkOutput("done_reached", 64'(got), 64'd1);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    checkOutput("write_count", 64'(writeCount), 64'd64);
  endtask

  // Output monitor: counts requests and pops the scoreboard on every write.
  always @(negedge clk) begin
    wr_t e;
    if (rnd_req) reqCount++;
    if (wr_en) begin
      writeCount++;
      captured[wr_addr] = wr_data;
      checkOutput("write_expected", 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
        checkOutput("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  // Directed sequence: reset, empty board, single mine, duplicates, ignored starts, mid-scan reset.
  initial begin
    logic [63:0] map;
    logic        got;
    rst         = 1'b1;
    start       = 1'b0;
    total_mines = 4'd0;
    rnd_valid   = 1'b0;
    rnd_row     = 3'd0;
    rnd_col     = 3'd0;
    clearRun();

    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
                {rnd_req, wr_en, busy, done, placed_count, wr_addr, wr_data} == '0 ? 64'd0 : 64'd1, 64'd0);
    checkOutput("reset_map", mine_map, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("idle_no_req", 64'(reqCount), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_done", 64'(done), 64'd0);

    // Zero mines: immediate scan of an all-zero board.
    $display("[TB] total_mines=0");
    clearRun();
    pushExpected(64'd0);
    applyStimulus(4'd0);
    waitDone();
    checkOutput("zero_no_req", 64'(reqCount), 64'd0);
    checkOutput("zero_map", mine_map, 64'd0);
    checkOutput("zero_done", 64'(done), 64'd1);

    // One mine at (2,3).
    $display("[TB] total_mines=1 at (2,3)");
    clearRun();
    map = 64'd0;
    map[19] = 1'b1;
    pushExpected(map);
    applyStimulus(4'd1);
    serveRnd(3'd2, 3'd3, 1);
    waitDone();
    checkOutput("one_reqs", 64'(reqCount), 64'd1);
    checkOutput("one_map", mine_map, 64'h0000_0000_0008_0000);
    checkOutput("one_placed", 64'(placed_count), 64'd1);
    checkOutput("one_cell19", 64'(captured[19]), 64'd9);
    checkOutput("one_cell10", 64'(captured[10]), 64'd1);
    checkOutput("one_cell28", 64'(captured[28]), 64'd1);
    checkOutput("one_cell0", 64'(captured[0]), 64'd0);

    // Corner mines with a duplicate and slow responses.
    $display("[TB] total_mines=2 corners with duplicate");
    clearRun();
    map = 64'd0;
    map[0]  = 1'b1;
    map[63] = 1'b1;
    pushExpected(map);
    applyStimulus(4'd2);
    serveRnd(3'd0, 3'd0, 3);
    checkOutput("dup_placed_first", 64'(placed_count), 64'd1);
    serveRnd(3'd0, 3'd0, 3);
    checkOutput("dup_placed_after", 64'(placed_count), 64'd1);
    serveRnd(3'd7, 3'd7, 3);
    waitDone();
    checkOutput("dup_reqs", 64'(reqCount), 64'd3);
    checkOutput("dup_placed", 64'(placed_count), 64'd2);
    checkOutput("dup_cell0", 64'(captured[0]), 64'd9);
    checkOutput("dup_cell63", 64'(captured[63]), 64'd9);
    checkOutput("dup_cell9", 64'(captured[9]), 64'd1);
    checkOutput("dup_cell54", 64'(captured[54]), 64'd1);

    // Starts during WAIT_RND and SCAN must be ignored.
    $display("[TB] start while busy");
    clearRun();
    map = 64'd0;
    map[9]  = 1'b1;
    map[37] = 1'b1;
    map[48] = 1'b1;
    pushExpected(map);
    applyStimulus(4'd3);
    serveRnd(3'd1, 3'd1, 1);
    waitReq("rnd_req_seen");
    @(negedge clk);
    start       = 1'b1;
    total_mines = 4'd7;
    @(negedge clk);
    start       = 1'b0;
    rnd_row     = 3'd4;
    rnd_col     = 3'd5;
    rnd_valid   = 1'b1;
    @(negedge clk);
    rnd_valid   = 1'b0;
    serveRnd(3'd6, 3'd0, 2);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (wr_en) got = 1'b1;
      else @(negedge clk);
    end
    checkOutput("scan_started", 64'(got), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    checkOutput("busy_start_reqs", 64'(reqCount), 64'd3);
    checkOutput("busy_start_placed", 64'(placed_count), 64'd3);
    checkOutput("busy_start_map", mine_map, map);

    // Fresh run from DONE, aborted by reset at scan index 30.
    $display("[TB] restart from DONE then reset mid-scan");
    clearRun();
    map = 64'd0;
    map[7]  = 1'b1;
    map[27] = 1'b1;
    map[42] = 1'b1;
    pushExpected(map);
    applyStimulus(4'd3);
    checkOutput("restart_map_cleared", mine_map, 64'd0);
    checkOutput("restart_busy", 64'(busy), 64'd1);
    checkOutput("restart_done", 64'(done), 64'd0);
    serveRnd(3'd0, 3'd7, 1);
    serveRnd(3'd3, 3'd3, 1);
    serveRnd(3'd5, 3'd2, 1);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 6'd30) got = 1'b1;
    end
    checkOutput("reached_idx30", 64'(got), 64'd1);
    #1 rst = 1'b1;
    #1;
    expQ.delete();
    checkOutput("abort_wr_en", 64'(wr_en), 64'd0);
    checkOutput("abort_outputs",
                {rnd_req, busy, done, placed_count, wr_addr, wr_data} == '0 ? 64'd0 : 64'd1, 64'd0);
    checkOutput("abort_map", mine_map, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_idx31", 64'(captured[31]), 64'hF);
    checkOutput("abort_write_count", 64'(writeCount), 64'd31);
    checkOutput("abort_idle_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
